// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector for raster-order {R,G,B} video with valid/ready
// on both sides. Emits interior pixels only, as a binary edge map or a saturated magnitude.
module sobel_stream_filter #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3*PIXEL_WIDTH-1:0] in_pixel,
  input  logic                     in_sof,
  input  logic [PIXEL_WIDTH+2:0]   threshold,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIXEL_WIDTH-1:0]   out_data,
  output logic                     out_sof,
  output logic                     out_eol
);

  localparam int PW  = PIXEL_WIDTH;
  localparam int PIX = 3 * PW;
  localparam int GW  = PW + 3;
  localparam int CW  = $clog2(IMAGE_WIDTH);
  localparam int RW  = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [GW-1:0] PIX_MAX  = {3'b000, {PW{1'b1}}};

  logic               en, accept;
  logic               started_q, mode_q;
  logic [GW-1:0]      thr_q;
  logic [CW-1:0]      col_q, col_cur, col_d;
  logic [RW-1:0]      row_q, row_cur, row_d;
  logic               centre_ok, at_first, s0_valid_d;
  logic               s0_valid_q, s0_sof_q, s0_eol_q, s0_mode_q;
  logic [GW-1:0]      s0_thr_q;
  logic [PIX-1:0]     lb1_q [IMAGE_WIDTH];
  logic [PIX-1:0]     lb2_q [IMAGE_WIDTH];
  logic [PIX-1:0]     win_q [3][3];
  logic [2:0][GW-1:0] gx_d, gy_d, s1_gx_q, s1_gy_q;
  logic               s1_valid_q, s1_sof_q, s1_eol_q, s1_mode_q;
  logic [GW-1:0]      s1_thr_q;
  logic [GW-1:0]      ax, ay, mag, m_max;
  logic [PW-1:0]      out_data_d, out_data_q;
  logic               out_valid_q, out_sof_q, out_eol_q;

  // A single enable stalls every stage together, so a held output never loses a beat.
  assign en       = !out_valid_q || out_ready;
  assign accept   = in_valid && en;
  assign in_ready = en;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

  function automatic logic [GW-1:0] chan(input logic [PIX-1:0] px, input int k);
    return {3'b000, px[k*PW +: PW]};
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;
    col_d   = col_cur + 1'b1;
    row_d   = row_cur;
    if (col_cur == COL_LAST) begin
      col_d = '0;
      row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
    end
    centre_ok  = (started_q || in_sof) && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
    at_first   = (row_cur == RW'(2)) && (col_cur == CW'(2));
    s0_valid_d = accept && centre_ok;
  end

  // Window column 2 is the newest beat, row 0 the oldest line; centre is win_q[1][1].
  always_comb begin
    gx_d = '0;
    gy_d = '0;
    for (int k = 0; k < 3; k++) begin
      gx_d[k] = (chan(win_q[0][2], k) + (chan(win_q[1][2], k) << 1) + chan(win_q[2][2], k))
              - (chan(win_q[0][0], k) + (chan(win_q[1][0], k) << 1) + chan(win_q[2][0], k));
      gy_d[k] = (chan(win_q[2][0], k) + (chan(win_q[2][1], k) << 1) + chan(win_q[2][2], k))
              - (chan(win_q[0][0], k) + (chan(win_q[0][1], k) << 1) + chan(win_q[0][2], k));
    end
  end

  always_comb begin
    ax    = '0;
    ay    = '0;
    mag   = '0;
    m_max = '0;
    for (int k = 0; k < 3; k++) begin
      ax  = s1_gx_q[k][GW-1] ? GW'(-s1_gx_q[k]) : s1_gx_q[k];
      ay  = s1_gy_q[k][GW-1] ? GW'(-s1_gy_q[k]) : s1_gy_q[k];
      mag = ax + ay;
      if (mag > m_max) m_max = mag;
    end
    if (s1_mode_q) out_data_d = (m_max > PIX_MAX) ? '1 : m_max[PW-1:0];
    else           out_data_d = (m_max >= s1_thr_q) ? '1 : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      started_q   <= 1'b0;
      mode_q      <= 1'b0;
      thr_q       <= '0;
      s0_valid_q  <= 1'b0;
      s0_sof_q    <= 1'b0;
      s0_eol_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
        if (in_sof) begin
          started_q <= 1'b1;
          mode_q    <= mode;
          thr_q     <= threshold;
        end
      end
      if (en) begin
        s0_valid_q  <= s0_valid_d;
        s0_sof_q    <= s0_valid_d && at_first;
        s0_eol_q    <= s0_valid_d && (col_cur == COL_LAST);
        s1_valid_q  <= s0_valid_q;
        s1_sof_q    <= s0_sof_q;
        s1_eol_q    <= s0_eol_q;
        out_valid_q <= s1_valid_q;
        out_data_q  <= out_data_d;
        out_sof_q   <= s1_sof_q;
        out_eol_q   <= s1_eol_q;
      end
    end
  end

  // NOTE: line buffers and window are pure datapath; valid flags gate them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[col_cur] <= lb1_q[col_cur];
      lb1_q[col_cur] <= in_pixel;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= lb2_q[col_cur];
      win_q[1][2] <= lb1_q[col_cur];
      win_q[2][2] <= in_pixel;
    end
    if (en) begin
      s0_mode_q <= in_sof ? mode : mode_q;
      s0_thr_q  <= in_sof ? threshold : thr_q;
      s1_mode_q <= s0_mode_q;
      s1_thr_q  <= s0_thr_q;
      s1_gx_q   <= gx_d;
      s1_gy_q   <= gy_d;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter on an 8x6 image: directed frames plus
// randomized frames, compared against a plain-arithmetic Sobel model through a scoreboard.
module tb_sobel_stream_filter;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          sof;
    logic          eol;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3*PW-1:0] in_pixel;
  logic            in_sof;
  logic [PW+2:0]   threshold;
  logic            mode;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_data;
  logic            out_sof;
  logic            out_eol;

  int   vectors     = 0;
  int   miscompares = 0;
  int   stall_cycles = 0;
  bit   rand_ready  = 1'b0;
  exp_t exp_q[$];
  logic [3*PW-1:0] img [H][W];

  sobel_stream_filter #(
    .PIXEL_WIDTH (PW),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_sof    (in_sof),
    .threshold (threshold),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int chan(int r, int c, int k);
    return int'(img[r][c][8*k +: 8]);
  endfunction

  function automatic int edge_mag(int r, int c);
    int best;
    best = 0;
    for (int k = 0; k < 3; k++) begin
      int gx, gy, mag;
      gx = (chan(r-1, c+1, k) + 2*chan(r, c+1, k) + chan(r+1, c+1, k))
         - (chan(r-1, c-1, k) + 2*chan(r, c-1, k) + chan(r+1, c-1, k));
      gy = (chan(r+1, c-1, k) + 2*chan(r+1, c, k) + chan(r+1, c+1, k))
         - (chan(r-1, c-1, k) + 2*chan(r-1, c, k) + chan(r-1, c+1, k));
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > best) best = mag;
    end
    return best;
  endfunction

  // Beat (r,c) with r,c >= 2 yields the output for centre (r-1,c-1).
  task automatic gen_expect(input int nbeats, input bit md, input int thr);
    int   r, c, m;
    exp_t e;
    for (int idx = 0; idx < nbeats; idx++) begin
      r = idx / W;
      c = idx % W;
      if (r >= 2 && c >= 2) begin
        m = edge_mag(r-1, c-1);
        if (md) e.data = (m > 255) ? 8'hFF : 8'(m);
        else    e.data = (m >= thr) ? 8'hFF : 8'h00;
        e.sof = (r == 2 && c == 2);
        e.eol = (c == W-1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_uniform(input logic [23:0] px);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = px;
  endtask

  task automatic fill_step(input logic [23:0] lo, input logic [23:0] hi);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? lo : hi;
  endtask

  task automatic fill_random(input int maxv);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = {8'($urandom_range(0, maxv)), 8'($urandom_range(0, maxv)), 8'($urandom_range(0, maxv))};
  endtask

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_cycles > 0) begin
        out_ready = 1'b0;
        stall_cycles--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic push(input logic [23:0] px, input bit sof, input bit md, input int thr);
    int guard;
    @(negedge clk);
    in_valid  = 1'b1;
    in_pixel  = px;
    in_sof    = sof;
    mode      = sof ? md : 1'($urandom);
    threshold = sof ? 11'(thr) : 11'($urandom);
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    vectors++;
    assert (guard < 200) else begin
      miscompares++;
      $error("FAIL push_timeout in_ready=%0b after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input bit md, input int thr,
                            input bit gaps, input int stall_at);
    gen_expect(nbeats, md, thr);
    for (int idx = 0; idx < nbeats; idx++) begin
      if (idx == stall_at) stall_cycles = 10;
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      push(img[idx / W][idx % W], idx == 0, md, thr);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain outstanding=%0d, required 0", exp_q.size());
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [9:0] prev_w;
    bit         prev_stall;
    exp_t       e;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          vectors++;
          assert ({out_valid, out_data, out_sof, out_eol} === {1'b1, prev_w}) else begin
            miscompares++;
            $error("FAIL stall_hold got v=%0b w=%0h, required v=1 w=%0h",
                   out_valid, {out_data, out_sof, out_eol}, prev_w);
          end
        end
        if (out_valid && !out_ready) begin
          vectors++;
          assert (in_ready === 1'b0) else begin
            miscompares++;
            $error("FAIL stall_in_ready got %0b, required 0", in_ready);
          end
        end
        if (out_valid && out_ready) begin
          vectors++;
          assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL extra_beat got data=%0h sof=%0b eol=%0b, required no beat",
                   out_data, out_sof, out_eol);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            assert ({out_data, out_sof, out_eol} === {e.data, e.sof, e.eol}) else begin
              miscompares++;
              $error("FAIL out_beat got data=%0h sof=%0b eol=%0b, required data=%0h sof=%0b eol=%0b",
                     out_data, out_sof, out_eol, e.data, e.sof, e.eol);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_w     = {out_data, out_sof, out_eol};
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    in_sof    = 1'b0;
    threshold = '0;
    mode      = 1'b0;

    #17;
    vectors += 4;
    assert (out_valid === 1'b0) else begin miscompares++; $error("FAIL rst_valid got %0b, required 0", out_valid); end
    assert (out_data === 8'h00) else begin miscompares++; $error("FAIL rst_data got %0h, required 0", out_data); end
    assert (out_sof === 1'b0)   else begin miscompares++; $error("FAIL rst_sof got %0b, required 0", out_sof); end
    assert (out_eol === 1'b0)   else begin miscompares++; $error("FAIL rst_eol got %0b, required 0", out_eol); end
    #6;
    rst_n = 1'b1;

    // 1: uniform frame gives no edges
    fill_uniform(24'h404040);
    send_frame(W*H, 1'b0, 1, 1'b0, -1);
    wait_drain();

    // 2: red step, magnitude then high threshold
    fill_step(24'h000000, 24'hFF0000);
    send_frame(W*H, 1'b1, 0, 1'b0, -1);
    send_frame(W*H, 1'b0, 1021, 1'b0, -1);
    wait_drain();

    // 3: same frame with a 10-cycle downstream stall mid-row
    send_frame(W*H, 1'b1, 0, 1'b0, 30);
    wait_drain();

    // 4: green+blue step saturates; small green step does not
    fill_step(24'h000000, 24'h006432);
    send_frame(W*H, 1'b1, 0, 1'b0, -1);
    fill_step(24'h000000, 24'h001900);
    send_frame(W*H, 1'b1, 0, 1'b0, -1);
    wait_drain();

    // 5: frame abandoned after 20 beats by a new sof
    fill_random(255);
    send_frame(20, 1'b1, 0, 1'b0, -1);
    fill_random(40);
    send_frame(W*H, 1'b1, 0, 1'b0, -1);
    wait_drain();

    // 6: asynchronous reset while an output is held
    fill_uniform(24'h404040);
    send_frame(30, 1'b0, 1, 1'b0, -1);
    stall_cycles = 1000;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (!out_valid && guard < 20);
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 2;
    assert (out_valid === 1'b0) else begin miscompares++; $error("FAIL async_rst_valid got %0b, required 0", out_valid); end
    assert (out_data === 8'h00) else begin miscompares++; $error("FAIL async_rst_data got %0h, required 0", out_data); end
    repeat (2) @(negedge clk);
    #1;
    exp_q.delete();
    stall_cycles = 0;
    #2;
    rst_n = 1'b1;
    send_frame(W*H, 1'b0, 1, 1'b0, -1);
    wait_drain();

    // 7: randomized frames with random backpressure and input gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      fill_random((f % 2 == 0) ? 255 : 31);
      send_frame(W*H, 1'($urandom), $urandom_range(0, 2047), 1'b1, -1);
    end
    wait_drain();
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
